data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, 32, byte address width.
REQ-002 The block SHALL have parameter DATA_W, 32, data word width.
REQ-003 The block SHALL have parameter MAX_LOCK, 4, maximum consecutive locked grants; used only when the lock feature is compiled in.
REQ-004 The block SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have ports req0/req1  in  1  access request from requester 0 (core data port) / requester 1 (loader/debug port).
REQ-007 The block SHALL have ports we0/we1  in  1  write enable per requester; 0 means read.
REQ-008 The block SHALL have ports addr0/addr1  in  ADDR_W and wdata0/wdata1  in  DATA_W: request address and write data.
REQ-009 The block SHALL have ports gnt0/gnt1  out  1  one-cycle grant; the access completes in this cycle.
REQ-010 The block SHALL have ports rdata0/rdata1  out  DATA_W  read data, valid while the matching gnt is high.
REQ-011 The block SHALL have ports mem_addr  out  ADDR_W, mem_should_write  out  1, mem_write_data  out  DATA_W, mem_read_data  in  DATA_W: the DataMemory port.

Function
REQ-012 The block SHALL implement FSM states IDLE, GNT0, GNT1, with the state held in a register and reset to IDLE.
REQ-013 The block SHALL treat req as a level signal: each GNTx cycle consumes exactly one transfer, and req still high in a GNTx cycle is a new request.
REQ-014 From any state, the next state SHALL be: neither req high -> IDLE; exactly one req high -> GNT of that requester; both high -> GNT of the requester not granted last (round robin).
REQ-015 The last_grant register SHALL update on every GNTx cycle and reset to 1, so requester 0 wins the first tie.
REQ-016 Grant latency SHALL be one cycle from req sampled high to gnt high; a sole requester holding req SHALL receive a grant every cycle after the first.
REQ-017 In GNTx, mem_addr, mem_write_data and mem_should_write (= wex) SHALL be driven combinationally from requester x, and rdatax SHALL equal mem_read_data.
REQ-018 In IDLE, mem_should_write SHALL be 0, mem_addr and mem_write_data SHALL be 0, and both gnt SHALL be 0.
REQ-019 At most one gnt SHALL be high in any cycle; rdata of the non-granted requester SHALL be 0.
REQ-020 Requesters SHALL hold we/addr/wdata stable from req high until gnt; a req dropped before its grant cycle SHALL withdraw the request, with no memory access.
REQ-021 A req dropped during its own GNTx cycle SHALL still complete that access, because the grant was decided on the prior edge.

Reset
REQ-022 Asserting reset_n low SHALL immediately force state=IDLE, gnt0=gnt1=0 and mem_should_write=0, including mid-grant, so no partial write reaches memory.
REQ-023 Deasserting reset_n SHALL be followed by at least one IDLE cycle before any grant.

Configuration
REQ-024 Macro DATA_MEM_ARB_LOCK_EN SHALL control the lock feature.
REQ-025 With DATA_MEM_ARB_LOCK_EN defined, the block SHALL add inputs lock0/lock1 (1 bit each); if lockx is high in a GNTx cycle with reqx high, GNTx SHALL repeat regardless of the other req.
REQ-026 With DATA_MEM_ARB_LOCK_EN defined, a lock counter SHALL limit locked repeats to MAX_LOCK consecutive grants, then force rotation when the other req is high; the counter SHALL clear on rotation, IDLE or reset.
REQ-027 Without DATA_MEM_ARB_LOCK_EN, the lock ports and counter SHALL be absent and REQ-014 SHALL apply unmodified.

Structure
REQ-028 Package riscv_mem_pkg SHALL hold the arbiter state enum (IDLE/GNT0/GNT1), requester ID constants (REQ_CORE=0, REQ_LOADER=1) and the default widths.
REQ-029 Sub-module rr_pick2 SHALL be the combinational 2-way round-robin selector (inputs req0, req1, last_grant; outputs pick_valid, pick_id), instantiated once.

Verification
REQ-030 Sole writer test: req0=1, we0=1, addr0=0x8, wdata0=0x7 for one cycle -> gnt0 high next cycle, mem_should_write=1, mem_addr=0x8; a later read of 0x8 returns rdata0=0x7.
REQ-031 Tie test: req0 and req1 both held high for 6 cycles after reset -> grants alternate gnt0,gnt1,gnt0,gnt1,... starting with gnt0; the two gnt are never high together.
REQ-032 Withdrawn request test: req1 high 1 cycle while GNT0 is in progress, then req1 low -> no gnt1 and no memory access for requester 1.
REQ-033 Reset mid-write test: reset_n pulled low during a GNT1 write cycle -> mem_should_write=0 within the same cycle and the memory word is unchanged.
REQ-034 Lock test (macro defined): lock0=1 with req0 and req1 held high -> exactly 4 consecutive gnt0 grants, then gnt1.
REQ-035 Throughput test: req0 held high for 10 cycles -> 10 consecutive gnt0 grants after the 1-cycle latency.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester IDs and default bus widths.
package riscv_mem_pkg;

    localparam int DEFAULT_ADDR_W   = 32;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_MAX_LOCK = 4;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the requester that was
// not granted last wins.
module rr_pick2
    import riscv_mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick_valid,
    output logic pick_id
);

    always_comb begin
        pick_valid = req0 | req1;
        if (req0 && req1) begin
            pick_id = ~last_grant;
        end else if (req1) begin
            pick_id = REQ_LOADER;
        end else begin
            pick_id = REQ_CORE;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory (one-cycle grants).
// Optional grant locking is compiled in with `define DATA_MEM_ARB_LOCK_EN.
module data_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_LOCK = DEFAULT_MAX_LOCK
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DATA_MEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_should_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("data_mem_arbiter: MAX_LOCK must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       pick_valid, pick_id;

    // The grant being served this cycle already counts as "last" for the
    // decision about the next cycle, so the picker sees the updated value.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == GNT0) begin
            last_grant_d = REQ_CORE;
        end else if (state_q == GNT1) begin
            last_grant_d = REQ_LOADER;
        end
    end

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_d),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

`ifdef DATA_MEM_ARB_LOCK_EN
    localparam int LOCK_CNT_W = $clog2(MAX_LOCK + 1);

    // lock_cnt_q counts consecutive grants in the current run, saturating at MAX_LOCK.
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        if (!pick_valid) begin
            state_d = IDLE;
        end else if (pick_id == REQ_LOADER) begin
            state_d = GNT1;
        end else begin
            state_d = GNT0;
        end
        if (state_q == GNT0 && lock0 && req0 && lock_cnt_q < LOCK_CNT_W'(MAX_LOCK)) begin
            state_d = GNT0;
        end else if (state_q == GNT1 && lock1 && req1 && lock_cnt_q < LOCK_CNT_W'(MAX_LOCK)) begin
            state_d = GNT1;
        end

        if (state_d == IDLE) begin
            lock_cnt_d = '0;
        end else if (state_d == state_q) begin
            lock_cnt_d = (lock_cnt_q == LOCK_CNT_W'(MAX_LOCK)) ? lock_cnt_q
                                                                : lock_cnt_q + LOCK_CNT_W'(1);
        end else begin
            lock_cnt_d = LOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    always_comb begin
        if (!pick_valid) begin
            state_d = IDLE;
        end else if (pick_id == REQ_LOADER) begin
            state_d = GNT1;
        end else begin
            state_d = GNT0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_LOADER;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Memory port is steered straight from the granted requester; the async
    // reset clears state_q, which drops the write strobe in the same cycle.
    always_comb begin
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        rdata0           = '0;
        rdata1           = '0;
        mem_addr         = '0;
        mem_should_write = 1'b0;
        mem_write_data   = '0;
        case (state_q)
            GNT0: begin
                gnt0             = 1'b1;
                rdata0           = mem_read_data;
                mem_addr         = addr0;
                mem_should_write = we0;
                mem_write_data   = wdata0;
            end
            GNT1: begin
                gnt1             = 1'b1;
                rdata1           = mem_read_data;
                mem_addr         = addr1;
                mem_should_write = we1;
                mem_write_data   = wdata1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word-addressed memory model.
// Define DATA_MEM_ARB_LOCK_EN to also exercise the lock feature.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
`ifdef DATA_MEM_ARB_LOCK_EN
    logic        lock0, lock1;
`endif
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_should_write;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:63];

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req0             (req0),
        .req1             (req1),
        .we0              (we0),
        .we1              (we1),
        .addr0            (addr0),
        .addr1            (addr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
`ifdef DATA_MEM_ARB_LOCK_EN
        .lock0            (lock0),
        .lock1            (lock1),
`endif
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .rdata0           (rdata0),
        .rdata1           (rdata1),
        .mem_addr         (mem_addr),
        .mem_should_write (mem_should_write),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_should_write) mem[mem_addr[7:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h0000_000A;
        mem[8] = 32'h0000_000B;
        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
`ifdef DATA_MEM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        #12;
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_we", {31'd0, mem_should_write}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        tick();
        reset_n = 1'b1;

        // Sole writer, then read back.
        req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'h7;
        check("wr_lat_gnt0", {31'd0, gnt0}, 32'd0);
        tick();
        check("wr_gnt0", {31'd0, gnt0}, 32'd1);
        check("wr_gnt1", {31'd0, gnt1}, 32'd0);
        check("wr_we", {31'd0, mem_should_write}, 32'd1);
        check("wr_addr", mem_addr, 32'h8);
        check("wr_data", mem_write_data, 32'h7);
        req0 = 0;
        tick();
        check("wr_idle_gnt0", {31'd0, gnt0}, 32'd0);
        check("wr_idle_we", {31'd0, mem_should_write}, 32'd0);
        check("wr_idle_addr", mem_addr, 32'd0);
        req0 = 1; we0 = 0; addr0 = 32'h8; wdata0 = 0;
        tick();
        check("rd_gnt0", {31'd0, gnt0}, 32'd1);
        check("rd_rdata0", rdata0, 32'h7);
        check("rd_rdata1", rdata1, 32'h0);
        check("rd_we", {31'd0, mem_should_write}, 32'd0);
        req0 = 0;
        tick();
        check("rd_idle_rdata0", rdata0, 32'h0);

        // Tie after reset: alternate starting with requester 0.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h20;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("tie%0d_gnt0", i), {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_gnt1", i), {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
            check($sformatf("tie%0d_rdata", i), (i % 2 == 0) ? rdata0 : rdata1,
                  (i % 2 == 0) ? 32'hA : 32'hB);
        end
        req0 = 0; req1 = 0;
        tick();
        check("tie_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Withdrawn request: req1 pulses inside a GNT0 cycle but is gone by the edge.
        req0 = 1; addr0 = 32'h10;
        tick();
        check("wd_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'hDEAD;
        #3;
        req1 = 0;
        tick();
        check("wd_gnt1", {31'd0, gnt1}, 32'd0);
        check("wd_we", {31'd0, mem_should_write}, 32'd0);
        tick();
        check("wd_gnt1_late", {31'd0, gnt1}, 32'd0);
        check("wd_mem", mem[9], 32'h0);

        // Reset during a GNT1 write.
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55;
        tick();
        check("rw_gnt1", {31'd0, gnt1}, 32'd1);
        check("rw_we", {31'd0, mem_should_write}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_rst_we", {31'd0, mem_should_write}, 32'd0);
        check("rw_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        check("rw_mem", mem[8], 32'hB);
        req1 = 0; we1 = 0;
        reset_n = 1'b1;
        tick();
        check("rw_post_idle", {30'd0, gnt1, gnt0}, 32'd0);

        // Throughput: sole requester held for 10 edges gets 10 back-to-back grants.
        req0 = 1; we0 = 0; addr0 = 32'h8;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("tp%0d_gnt0", i), {31'd0, gnt0}, 32'd1);
            check($sformatf("tp%0d_rdata0", i), rdata0, 32'h7);
        end
        req0 = 0;
        tick();
        check("tp_end_gnt0", {31'd0, gnt0}, 32'd0);

`ifdef DATA_MEM_ARB_LOCK_EN
        // Lock: four consecutive grants to requester 0, then forced rotation.
        do_reset();
        req0 = 1; req1 = 1; lock0 = 1; addr0 = 32'h10; addr1 = 32'h20;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("lk%0d_gnt0", i), {31'd0, gnt0}, (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("lk%0d_gnt1", i), {31'd0, gnt1}, (i == 4) ? 32'd1 : 32'd0);
        end
        req0 = 0; req1 = 0; lock0 = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
